// File: rtl/heart_player_if.sv
// heart_player_if: ROM/LED bundle between heart_player (master) and its ROM/board side (slave).
// Signals: enable (playback enable), address (ROM select), db_entry (ROM data),
//          led (LED drive), frame_strobe (new-pattern pulse).
interface heart_player_if;
  logic       enable;
  logic [2:0] address;
  logic [7:0] db_entry;
  logic [7:0] led;
  logic       frame_strobe;
  modport master (input enable, db_entry, output address, led, frame_strobe);
  modport slave (output enable, db_entry, input address, led, frame_strobe);
endinterface

// File: rtl/heart_player.sv
// heart_player: sequences the 8-entry heart ROM and plays each pattern as PWM fade-in, hold, fade-out.
// Ports: clk, rst_n (async active-low), bus (heart_player_if.master:
//        enable in, db_entry in, address out, led out, frame_strobe out).
// Macro HEART_GAMMA_EN: squared (perceptual) duty curve during fades; linear when undefined.
module heart_player #(
  parameter int PRESCALE     = 4096,
  parameter int PWM_BITS     = 4,
  parameter int HOLD_PERIODS = 16
) (
  input logic           clk,
  input logic           rst_n,
  heart_player_if.master bus
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int HW = $clog2(HOLD_PERIODS) + 1;
  localparam logic [PWM_BITS-1:0] MAX = '1;
  typedef enum logic [2:0] {IDLE, LOAD, FADE_IN, HOLD, FADE_OUT, ADVANCE} state_t;
  state_t              state_q;
  logic [2:0]          address_q;
  logic [7:0]          led_q, pattern_q;
  logic                strobe_q;
  logic [PWM_BITS-1:0] level_q, pwm_q, duty_d;
  logic [PW-1:0]       presc_q;
  logic [HW-1:0]       hold_q;
  logic                tick_d, period_end_d;
  assign tick_d       = presc_q == PW'(PRESCALE - 1);
  assign period_end_d = tick_d && pwm_q == MAX;
`ifdef HEART_GAMMA_EN
  // upper half of level^2 gives the perceptual curve
  assign duty_d = PWM_BITS'(({{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q}) >> PWM_BITS);
`else
  assign duty_d = level_q;
`endif
  assign bus.address      = address_q;
  assign bus.led          = led_q;
  assign bus.frame_strobe = strobe_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      address_q <= '0;
      led_q     <= '0;
      strobe_q  <= 1'b0;
      pattern_q <= '0;
      level_q   <= '0;
      presc_q   <= '0;
      pwm_q     <= '0;
      hold_q    <= '0;
    end else begin
      strobe_q <= 1'b0;
      if (state_q != IDLE && !bus.enable) begin
        // pause: address and pattern survive so the same frame restarts
        state_q <= IDLE;
        led_q   <= '0;
        level_q <= '0;
        presc_q <= '0;
        pwm_q   <= '0;
        hold_q  <= '0;
      end else begin
        presc_q <= tick_d ? '0 : presc_q + 1'b1;
        pwm_q   <= tick_d ? pwm_q + 1'b1 : pwm_q;
        led_q   <= state_q == HOLD ? pattern_q :
                   (state_q == FADE_IN || state_q == FADE_OUT) ? pattern_q & {8{pwm_q < duty_d}} : '0;
        case (state_q)
          IDLE: begin
            presc_q <= '0;
            pwm_q   <= '0;
            if (bus.enable) state_q <= LOAD;
          end
          LOAD: begin
            pattern_q <= bus.db_entry;
            strobe_q  <= 1'b1;
            presc_q   <= '0;
            pwm_q     <= '0;
            level_q   <= '0;
            state_q   <= FADE_IN;
          end
          FADE_IN:
            if (period_end_d) begin
              if (level_q == MAX) begin
                state_q <= HOLD;
                hold_q  <= '0;
              end else level_q <= level_q + 1'b1;
            end
          HOLD:
            if (period_end_d) begin
              hold_q <= hold_q + 1'b1;
              if (hold_q == HW'(HOLD_PERIODS - 1)) begin
                state_q <= FADE_OUT;
                level_q <= MAX;
              end
            end
          FADE_OUT:
            if (period_end_d) begin
              if (level_q == '0) state_q <= ADVANCE;
              else level_q <= level_q - 1'b1;
            end
          ADVANCE: begin
            address_q <= address_q + 1'b1;
            state_q   <= LOAD;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_heart_player.sv
// tb_heart_player: directed checks of heart_player with PRESCALE=2, PWM_BITS=2, HOLD_PERIODS=2.
module tb_heart_player;
  localparam int PRESCALE = 2, PWM_BITS = 2, HOLD_PERIODS = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  int total = 0, bad = 0;
  logic [7:0] rom [0:7];
  logic [7:0] tr [0:81];
  int st_cnt;
  heart_player_if bus();
  assign bus.db_entry = rom[bus.address];
  heart_player #(.PRESCALE(PRESCALE), .PWM_BITS(PWM_BITS), .HOLD_PERIODS(HOLD_PERIODS))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task step;
    @(posedge clk);
    @(negedge clk);
  endtask
  // frame starts at t=0 (strobe visible); records led for t=0..81, leaves at t=82
  task capture;
    st_cnt = 0;
    for (int t = 0; t < 82; t++) begin
      tr[t] = bus.led;
      if (t > 0 && bus.frame_strobe) st_cnt++;
      step;
    end
  endtask
  task wait_strobe;
    int n;
    n = 0;
    do begin
      step;
      n++;
    end while (!bus.frame_strobe && n < 200);
    total++;
    if (!bus.frame_strobe) begin bad++; $display("FAIL wait_strobe got=timeout exp=strobe within 200"); end
  endtask
  task test_reset;
    rst_n = 1'b0;
    bus.enable = 1'b0;
    step;
    step;
    total++; if (bus.led !== 8'h00) begin bad++; $display("FAIL reset_led got=%h exp=00", bus.led); end
    total++; if (bus.address !== 3'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", bus.address); end
    total++; if (bus.frame_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b exp=0", bus.frame_strobe); end
    rst_n = 1'b1;
    step;
    step;
    total++; if (bus.frame_strobe !== 1'b0 || bus.led !== 8'h00) begin bad++; $display("FAIL idle_quiet got=%b/%h exp=0/00", bus.frame_strobe, bus.led); end
  endtask
  task test_first_frame;
    int nz;
    bus.enable = 1'b1;
    step;
    total++; if (bus.frame_strobe !== 1'b0) begin bad++; $display("FAIL first_load got=%b exp=0", bus.frame_strobe); end
    step;
    total++; if (bus.frame_strobe !== 1'b1) begin bad++; $display("FAIL first_strobe got=%b exp=1", bus.frame_strobe); end
    total++; if (bus.address !== 3'd0) begin bad++; $display("FAIL first_addr got=%0d exp=0", bus.address); end
    capture;
    nz = 0;
    for (int t = 0; t < 82; t++) if (tr[t] !== 8'h00) nz++;
    total++; if (nz != 0) begin bad++; $display("FAIL frame0_dark got=%0d lit cycles exp=0", nz); end
    total++; if (bus.frame_strobe !== 1'b1 || st_cnt != 0) begin bad++; $display("FAIL frame0_spacing got=%b/%0d exp=1/0", bus.frame_strobe, st_cnt); end
    total++; if (bus.address !== 3'd1) begin bad++; $display("FAIL frame0_next_addr got=%0d exp=1", bus.address); end
  endtask
  task test_fade_frame;
    int fin [4];
    int on, odd;
`ifdef HEART_GAMMA_EN
    fin = '{0, 0, 2, 4};
`else
    fin = '{0, 2, 4, 6};
`endif
    capture;
    odd = 0;
    for (int t = 0; t < 82; t++) if (tr[t] !== 8'h00 && tr[t] !== 8'h1E) odd++;
    total++; if (odd != 0) begin bad++; $display("FAIL fade_values got=%0d odd cycles exp=0", odd); end
    for (int p = 0; p < 4; p++) begin
      on = 0;
      for (int t = 1 + 8 * p; t <= 8 + 8 * p; t++) if (tr[t] === 8'h1E) on++;
      total++; if (on != fin[p]) begin bad++; $display("FAIL fade_in_p%0d got=%0d exp=%0d", p, on, fin[p]); end
      on = 0;
      for (int t = 49 + 8 * p; t <= 56 + 8 * p; t++) if (tr[t] === 8'h1E) on++;
      total++; if (on != fin[3 - p]) begin bad++; $display("FAIL fade_out_p%0d got=%0d exp=%0d", p, on, fin[3 - p]); end
    end
    on = 0;
    for (int t = 33; t <= 48; t++) if (tr[t] === 8'h1E) on++;
    total++; if (on != 16) begin bad++; $display("FAIL hold_on got=%0d exp=16", on); end
    total++; if (tr[81] !== 8'h00 || tr[0] !== 8'h00) begin bad++; $display("FAIL frame_edges got=%h/%h exp=00/00", tr[0], tr[81]); end
    total++; if (bus.frame_strobe !== 1'b1 || st_cnt != 0 || bus.address !== 3'd2) begin bad++; $display("FAIL frame1_next got=%b/%0d/%0d exp=1/0/2", bus.frame_strobe, st_cnt, bus.address); end
  endtask
  task test_free_run;
    for (int k = 2; k < 11; k++) begin
      capture;
      total++; if (tr[40] !== rom[k % 8]) begin bad++; $display("FAIL run_pattern a=%0d got=%h exp=%h", k % 8, tr[40], rom[k % 8]); end
      total++; if (bus.frame_strobe !== 1'b1 || st_cnt != 0) begin bad++; $display("FAIL run_spacing a=%0d got=%b/%0d exp=1/0", k % 8, bus.frame_strobe, st_cnt); end
      total++; if (bus.address !== 3'((k + 1) % 8)) begin bad++; $display("FAIL run_addr got=%0d exp=%0d", bus.address, (k + 1) % 8); end
    end
  endtask
  task test_enable_drop;
    for (int i = 0; i < 40; i++) step;
    total++; if (bus.led !== 8'h7E) begin bad++; $display("FAIL drop_pre_hold got=%h exp=7e", bus.led); end
    bus.enable = 1'b0;
    step;
    total++; if (bus.led !== 8'h00) begin bad++; $display("FAIL drop_led got=%h exp=00", bus.led); end
    step;
    step;
    total++; if (bus.led !== 8'h00 || bus.frame_strobe !== 1'b0 || bus.address !== 3'd3) begin bad++; $display("FAIL drop_idle got=%h/%b/%0d exp=00/0/3", bus.led, bus.frame_strobe, bus.address); end
    bus.enable = 1'b1;
    step;
    total++; if (bus.frame_strobe !== 1'b0) begin bad++; $display("FAIL reen_load got=%b exp=0", bus.frame_strobe); end
    step;
    total++; if (bus.frame_strobe !== 1'b1 || bus.address !== 3'd3) begin bad++; $display("FAIL reen_strobe got=%b/%0d exp=1/3", bus.frame_strobe, bus.address); end
    for (int i = 0; i < 40; i++) step;
    total++; if (bus.led !== 8'h7E) begin bad++; $display("FAIL reen_pattern got=%h exp=7e", bus.led); end
  endtask
  task test_async_reset;
    wait_strobe;
    wait_strobe;
    total++; if (bus.address !== 3'd5) begin bad++; $display("FAIL rst_pre_addr got=%0d exp=5", bus.address); end
    for (int i = 0; i < 60; i++) step;
    total++; if (bus.led !== 8'h7E) begin bad++; $display("FAIL rst_pre_led got=%h exp=7e", bus.led); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.led !== 8'h00 || bus.address !== 3'd0 || bus.frame_strobe !== 1'b0) begin bad++; $display("FAIL async_rst got=%h/%0d/%b exp=00/0/0", bus.led, bus.address, bus.frame_strobe); end
    @(negedge clk);
    step;
    rst_n = 1'b1;
    step;
    total++; if (bus.frame_strobe !== 1'b0) begin bad++; $display("FAIL post_rst_load got=%b exp=0", bus.frame_strobe); end
    step;
    total++; if (bus.frame_strobe !== 1'b1 || bus.address !== 3'd0) begin bad++; $display("FAIL post_rst_strobe got=%b/%0d exp=1/0", bus.frame_strobe, bus.address); end
  endtask
  initial begin
    rom[0] = 8'h00; rom[1] = 8'h1E; rom[2] = 8'h3F; rom[3] = 8'h7E;
    rom[4] = 8'hFC; rom[5] = 8'h7E; rom[6] = 8'h3F; rom[7] = 8'h1E;
    test_reset;
    test_first_frame;
    test_fade_frame;
    test_free_run;
    test_enable_drop;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
